mux2b_arb_stream: RTL and testbench

Two-input, one-output stream merger with round-robin packet arbitration. It performs the reverse of the design's 1-bit enable-gated demultiplexer: that block fans one stream out to two destinations, and this block gathers two source streams onto one shared link. A grant is held for a whole packet, delimited by a last flag, so packets from different sources never interleave. Output is registered, and each side uses valid/ready handshakes.

---
 rtl/mux2b_arb_stream.sv | 152 +++++++++++++++
 tb/tb_mux2b_arb_stream.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mux2b_arb_stream.sv
// mux2b_arb_stream: merges two valid/ready packet streams onto one registered output link.
// Round-robin packet grant by default; define MUX2B_FIXED_PRIO_EN for fixed channel-0 priority.
module mux2b_arb_stream #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [WIDTH-1:0] x0,
    input  logic [WIDTH-1:0] x1,
    input  logic             v0,
    input  logic             v1,
    input  logic             l0,
    input  logic             l1,
    output logic             r0,
    output logic             r1,
    output logic [WIDTH-1:0] y,
    output logic             y_valid,
    output logic             y_last,
    input  logic             y_ready,
    output logic             sel,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] y_r;
    logic             y_valid_r;
    logic             y_last_r;
    logic             sel_r;

    logic             load_s;
    logic             r0_s;
    logic             r1_s;
    logic             xfer0_s;
    logic             xfer1_s;
    logic             req_s;
    logic             pick_s;

`ifndef MUX2B_FIXED_PRIO_EN
    logic             rr_r;
`endif

    // Ready generation: only the granted source may transfer, and only into a free or draining register.
    always_comb begin
        load_s  = !y_valid_r || y_ready;
        r0_s    = (state_r == GRANT0) && enable && load_s;
        r1_s    = (state_r == GRANT1) && enable && load_s;
        xfer0_s = v0 && r0_s;
        xfer1_s = v1 && r1_s;
    end

    // Arbitration choice taken from IDLE; on a tie the channel not served last wins.
    always_comb begin
        req_s = enable && (v0 || v1);
        if (v0 && v1) begin
`ifdef MUX2B_FIXED_PRIO_EN
            pick_s = 1'b0;
`else
            pick_s = ~rr_r;
`endif
        end else if (v1) begin
            pick_s = 1'b1;
        end else begin
            pick_s = 1'b0;
        end
    end

    // Packet grant FSM; a grant is released only after the last beat has been handshaken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            sel_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_s) begin
                        state_r <= pick_s ? GRANT1 : GRANT0;
                        sel_r   <= pick_s;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                GRANT0: begin
                    if (xfer0_s && l0) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= GRANT0;
                    end
                end
                GRANT1: begin
                    if (xfer1_s && l1) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= GRANT1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

`ifndef MUX2B_FIXED_PRIO_EN
    // Last-served pointer; resets to 1 so channel 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_r <= 1'b1;
        end else if ((state_r == IDLE) && req_s) begin
            rr_r <= pick_s;
        end else begin
            rr_r <= rr_r;
        end
    end
`endif

    // Output register: loads on an input handshake, otherwise empties once downstream accepts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_r       <= '0;
            y_valid_r <= 1'b0;
            y_last_r  <= 1'b0;
        end else if (xfer0_s) begin
            y_r       <= x0;
            y_valid_r <= 1'b1;
            y_last_r  <= l0;
        end else if (xfer1_s) begin
            y_r       <= x1;
            y_valid_r <= 1'b1;
            y_last_r  <= l1;
        end else if (y_valid_r && y_ready) begin
            y_valid_r <= 1'b0;
        end else begin
            y_valid_r <= y_valid_r;
        end
    end

    assign r0      = r0_s;
    assign r1      = r1_s;
    assign y       = y_r;
    assign y_valid = y_valid_r;
    assign y_last  = y_last_r;
    assign sel     = sel_r;
    assign busy    = (state_r != IDLE);

endmodule

// File: tb/tb_mux2b_arb_stream.sv
// Bench for mux2b_arb_stream: directed cycle vectors, then random packet traffic
// checked against a packet-level scoreboard with ordering and fairness rules.
module tb_mux2b_arb_stream;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [7:0] x0, x1;
    logic       v0, v1, l0, l1;
    logic       r0, r1;
    logic [7:0] y;
    logic       y_valid, y_last, y_ready;
    logic       sel, busy;

    int checks = 0;
    int errors = 0;

    mux2b_arb_stream #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .x0(x0), .x1(x1), .v0(v0), .v1(v1), .l0(l0), .l1(l1),
        .r0(r0), .r1(r1), .y(y), .y_valid(y_valid), .y_last(y_last),
        .y_ready(y_ready), .sel(sel), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst, en, v0, l0;
        logic [7:0] x0;
        logic       v1, l1;
        logic [7:0] x1;
        logic       yr;
        logic       r0, r1;
        logic [7:0] y;
        logic       yv, yl, sel, busy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, en, v0_i, l0_i, input logic [7:0] x0_i,
                                input logic v1_i, l1_i, input logic [7:0] x1_i, input logic yr,
                                input logic er0, er1, input logic [7:0] ey,
                                input logic eyv, eyl, esel, ebusy);
        vec_t t;
        t = '{rst, en, v0_i, l0_i, x0_i, v1_i, l1_i, x1_i, yr, er0, er1, ey, eyv, eyl, esel, ebusy};
        return t;
    endfunction

    // scoreboard and source state for the random phase
    logic       act[2];
    logic       sent[2];
    int         rem[2];
    int         seq[2];
    logic [8:0] exp_q[$];
    int         cur_ch, last_ch;
    logic       arm_wait, other_waiting, prev_hold, prev_last;
    logic [7:0] prev_y;

    task automatic rand_cycle(input logic gen_on);
        logic [1:0] vv;
        logic [1:0] ll;
        logic [1:0] hs;
        logic [7:0] xx [2];
        logic [8:0] e;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            if (!act[k] && gen_on && ($urandom_range(0, 99) < 30)) begin
                act[k]  = 1'b1;
                rem[k]  = $urandom_range(1, 4);
                sent[k] = 1'b0;
            end
            vv[k] = act[k] && !(sent[k] && ($urandom_range(0, 99) < 20));
            xx[k] = {k[0], seq[k][6:0]};
            ll[k] = (rem[k] == 1);
        end
        v0 = vv[0]; x0 = xx[0]; l0 = ll[0];
        v1 = vv[1]; x1 = xx[1]; l1 = ll[1];
        enable  = gen_on ? ($urandom_range(0, 99) < 90) : 1'b1;
        y_ready = gen_on ? ($urandom_range(0, 99) < 75) : 1'b1;
        #1;
        checks++;
        if ((r0 && r1) || (!enable && (r0 || r1)) || (y_valid && !y_ready && (r0 || r1))) begin
            errors++;
            $display("FAIL ready_rule r0=%b r1=%b enable=%b y_valid=%b y_ready=%b", r0, r1, enable, y_valid, y_ready);
        end
        if (prev_hold) begin
            checks++;
            if (!y_valid || y !== prev_y || y_last !== prev_last) begin
                errors++;
                $display("FAIL hold got y=%h v=%b last=%b want y=%h v=1 last=%b", y, y_valid, y_last, prev_y, prev_last);
            end
        end
        if (y_valid && y_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL spurious_beat got y=%h last=%b want none", y, y_last);
            end else begin
                e = exp_q.pop_front();
                if ({y_last, y} !== e) begin
                    errors++;
                    $display("FAIL beat got last=%b y=%h want last=%b y=%h", y_last, y, e[8], e[7:0]);
                end
            end
        end
        if (arm_wait) begin
            other_waiting = vv[1 - last_ch];
            arm_wait = 1'b0;
        end
        hs[0] = vv[0] && r0;
        hs[1] = vv[1] && r1;
        for (int k = 0; k < 2; k++) begin
            if (hs[k]) begin
                checks++;
                if (cur_ch < 0) begin
                    if (last_ch == k && other_waiting) begin
                        errors++;
                        $display("FAIL fairness got ch%0d again want ch%0d", k, 1 - k);
                    end
                    cur_ch = k;
                end else if (cur_ch != k) begin
                    errors++;
                    $display("FAIL interleave got ch%0d want ch%0d", k, cur_ch);
                end
                exp_q.push_back({ll[k], xx[k]});
                seq[k]++;
                rem[k]--;
                sent[k] = 1'b1;
                if (ll[k]) begin
                    act[k] = 1'b0;
                    cur_ch = -1;
                    last_ch = k;
                    arm_wait = 1'b1;
                    other_waiting = 1'b0;
                end
            end
        end
        prev_hold = y_valid && !y_ready;
        prev_y    = y;
        prev_last = y_last;
    endtask

    initial begin
        logic [13:0] got, expv;
        rst_n = 1'b0; enable = 1'b0; y_ready = 1'b0;
        v0 = 1'b0; v1 = 1'b0; l0 = 1'b0; l1 = 1'b0; x0 = 8'h00; x1 = 8'h00;

        // rst en v0 l0 x0 v1 l1 x1 yr | r0 r1 y yv yl sel busy
        vecs.push_back(mk(1,1,0,0,8'h00,0,0,8'h00,1, 0,0,8'h00,0,0,0,0));
        vecs.push_back(mk(0,1,1,0,8'hA1,0,0,8'h00,1, 0,0,8'h00,0,0,0,0));
        vecs.push_back(mk(0,1,1,0,8'hA1,0,0,8'h00,1, 1,0,8'h00,0,0,0,1));
        vecs.push_back(mk(0,1,1,0,8'hB2,0,0,8'h00,1, 1,0,8'hA1,1,0,0,1));
        vecs.push_back(mk(0,1,1,1,8'hC3,0,0,8'h00,1, 1,0,8'hB2,1,0,0,1));
        vecs.push_back(mk(0,1,0,0,8'h00,0,0,8'h00,1, 0,0,8'hC3,1,1,0,0));
        vecs.push_back(mk(0,1,0,0,8'h00,0,0,8'h00,1, 0,0,8'hC3,0,1,0,0));
        // tie from reset: ch0, ch1, ch0 with a bubble between packets
        vecs.push_back(mk(1,1,1,0,8'h01,1,0,8'h11,1, 0,0,8'h00,0,0,0,0));
        vecs.push_back(mk(0,1,1,0,8'h01,1,0,8'h11,1, 0,0,8'h00,0,0,0,0));
        vecs.push_back(mk(0,1,1,0,8'h01,1,0,8'h11,1, 1,0,8'h00,0,0,0,1));
        vecs.push_back(mk(0,1,1,1,8'h02,1,0,8'h11,1, 1,0,8'h01,1,0,0,1));
        vecs.push_back(mk(0,1,1,0,8'h03,1,0,8'h11,1, 0,0,8'h02,1,1,0,0));
        vecs.push_back(mk(0,1,1,0,8'h03,1,0,8'h11,1, 0,1,8'h02,0,1,1,1));
        vecs.push_back(mk(0,1,1,0,8'h03,1,1,8'h12,1, 0,1,8'h11,1,0,1,1));
        vecs.push_back(mk(0,1,1,0,8'h03,1,0,8'h13,1, 0,0,8'h12,1,1,1,0));
        vecs.push_back(mk(0,1,1,0,8'h03,1,0,8'h13,1, 1,0,8'h12,0,1,0,1));
        // backpressure for 4 cycles mid-packet
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(0,1,1,0,8'h04,1,0,8'h13,0, 0,0,8'h03,1,0,0,1));
        vecs.push_back(mk(0,1,1,0,8'h04,1,0,8'h13,1, 1,0,8'h03,1,0,0,1));
        vecs.push_back(mk(0,1,1,1,8'h05,1,0,8'h13,1, 1,0,8'h04,1,0,0,1));
        vecs.push_back(mk(0,1,0,0,8'h00,1,0,8'h13,1, 0,0,8'h05,1,1,0,0));
        vecs.push_back(mk(0,1,0,0,8'h00,1,0,8'h13,1, 0,1,8'h05,0,1,1,1));
        // enable low for 3 cycles mid ch1 packet, ch0 waiting
        vecs.push_back(mk(0,0,1,0,8'h06,1,0,8'h14,1, 0,0,8'h13,1,0,1,1));
        vecs.push_back(mk(0,0,1,0,8'h06,1,0,8'h14,1, 0,0,8'h13,0,0,1,1));
        vecs.push_back(mk(0,0,1,0,8'h06,1,0,8'h14,1, 0,0,8'h13,0,0,1,1));
        vecs.push_back(mk(0,1,1,0,8'h06,1,0,8'h14,1, 0,1,8'h13,0,0,1,1));
        vecs.push_back(mk(0,1,1,0,8'h06,1,1,8'h15,1, 0,1,8'h14,1,0,1,1));
        vecs.push_back(mk(0,1,1,0,8'h06,0,0,8'h00,1, 0,0,8'h15,1,1,1,0));
        vecs.push_back(mk(0,1,1,0,8'h06,0,0,8'h00,1, 1,0,8'h15,0,1,0,1));
        // v1 rises during ch0 last beat: ch1 next, ch0's new packet after it
        vecs.push_back(mk(0,1,1,1,8'h07,1,1,8'h21,1, 1,0,8'h06,1,0,0,1));
        vecs.push_back(mk(0,1,1,1,8'h08,1,1,8'h21,1, 0,0,8'h07,1,1,0,0));
        vecs.push_back(mk(0,1,1,1,8'h08,1,1,8'h21,1, 0,1,8'h07,0,1,1,1));
        vecs.push_back(mk(0,1,1,1,8'h08,0,0,8'h00,1, 0,0,8'h21,1,1,1,0));
        vecs.push_back(mk(0,1,1,1,8'h08,0,0,8'h00,1, 1,0,8'h21,0,1,0,1));
        vecs.push_back(mk(0,1,0,0,8'h00,0,0,8'h00,1, 0,0,8'h08,1,1,0,0));
        vecs.push_back(mk(0,1,0,0,8'h00,0,0,8'h00,1, 0,0,8'h08,0,1,0,0));
        // reset while idle, then reset mid-packet with a beat in the output register
        vecs.push_back(mk(1,1,0,0,8'h00,0,0,8'h00,1, 0,0,8'h00,0,0,0,0));
        vecs.push_back(mk(0,1,1,0,8'h31,0,0,8'h00,1, 0,0,8'h00,0,0,0,0));
        vecs.push_back(mk(0,1,1,0,8'h31,0,0,8'h00,1, 1,0,8'h00,0,0,0,1));
        vecs.push_back(mk(0,1,1,0,8'h32,0,0,8'h00,1, 1,0,8'h31,1,0,0,1));
        vecs.push_back(mk(1,1,1,0,8'h32,0,0,8'h00,1, 0,0,8'h00,0,0,0,0));
        vecs.push_back(mk(0,1,1,0,8'h31,0,0,8'h00,1, 0,0,8'h00,0,0,0,0));
        vecs.push_back(mk(0,1,1,0,8'h31,0,0,8'h00,1, 1,0,8'h00,0,0,0,1));
        vecs.push_back(mk(0,1,1,1,8'h32,0,0,8'h00,1, 1,0,8'h31,1,0,0,1));
        vecs.push_back(mk(0,1,0,0,8'h00,0,0,8'h00,1, 0,0,8'h32,1,1,0,0));

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst_n = !vecs[i].rst; enable = vecs[i].en; y_ready = vecs[i].yr;
            v0 = vecs[i].v0; l0 = vecs[i].l0; x0 = vecs[i].x0;
            v1 = vecs[i].v1; l1 = vecs[i].l1; x1 = vecs[i].x1;
            #1;
            got  = {r0, r1, y, y_valid, y_last, sel, busy};
            expv = {vecs[i].r0, vecs[i].r1, vecs[i].y, vecs[i].yv, vecs[i].yl, vecs[i].sel, vecs[i].busy};
            checks++;
            if (got !== expv) begin
                errors++;
                $display("FAIL vec%0d got {r0,r1,y,yv,yl,sel,busy}=%h want %h", i, got, expv);
            end
        end

        // random traffic from a clean reset
        @(negedge clk);
        rst_n = 1'b0; v0 = 1'b0; v1 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            act[k] = 1'b0; sent[k] = 1'b0; rem[k] = 0; seq[k] = 0;
        end
        cur_ch = -1; last_ch = -1;
        arm_wait = 1'b0; other_waiting = 1'b0; prev_hold = 1'b0; prev_last = 1'b0; prev_y = 8'h00;
        for (int n = 0; n < 3000; n++) rand_cycle(1'b1);
        for (int n = 0; n < 2000 && (act[0] || act[1] || exp_q.size() != 0 || y_valid); n++)
            rand_cycle(1'b0);
        checks++;
        if (act[0] || act[1] || exp_q.size() != 0 || y_valid) begin
            errors++;
            $display("FAIL drain got pending=%0d y_valid=%b want 0 0", exp_q.size(), y_valid);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
